// File: rtl/hcsr04_pkg.sv
// Shared HC-SR04 definitions: FSM state encoding, default cycle constants
// at 50 MHz, and a counter-width helper used by the trigger and echo stages.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_ECHO_HIGH = 3'd3,
    ST_HOLDOFF   = 3'd4
  } hcsr04_state_t;

  // 10 us trigger pulse, 38 ms echo window, 60 ms ranging period at 50 MHz
  localparam int unsigned HCSR04_TRIG_CYCLES         = 500;
  localparam int unsigned HCSR04_ECHO_TIMEOUT_CYCLES = 1_900_000;
  localparam int unsigned HCSR04_PERIOD_CYCLES       = 3_000_000;

  // Bits needed for a counter that must hold max_val (never narrower than 1)
  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hcsr04_sync2.sv
// Two-flop synchronizer for the raw echo pin; both flops clear on reset.
module hcsr04_sync2 (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic Async_i,
  output logic Sync_o
);

  logic meta_reg;
  logic sync_reg;

  // Shift the asynchronous input through two flops
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= Async_i;
      sync_reg <= meta_reg;
    end
  end

  assign Sync_o = sync_reg;

endmodule

// File: rtl/ultrasonic_sensor_trigger.sv
// HC-SR04 trigger sequencer: issues the trigger pulse, watches the
// synchronized echo for a valid high pulse or a timeout, then holds off
// until the ranging period has elapsed.
module ultrasonic_sensor_trigger
  import hcsr04_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES         = HCSR04_TRIG_CYCLES,
  parameter int unsigned ECHO_TIMEOUT_CYCLES = HCSR04_ECHO_TIMEOUT_CYCLES,
  parameter int unsigned PERIOD_CYCLES       = HCSR04_PERIOD_CYCLES
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic Enable_i,
  input  logic Start_i,
  input  logic Echo_i,
  output logic Trigger_o,
  output logic Echo_sync_o,
  output logic Busy_o,
  output logic Done_o,
  output logic Timeout_o
);

  localparam int TRIG_W = cnt_width(TRIG_CYCLES - 1);
  localparam int TMO_W  = cnt_width(ECHO_TIMEOUT_CYCLES);
  localparam int PER_W  = cnt_width(PERIOD_CYCLES - 1);

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ECHO_TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(ECHO_TIMEOUT_CYCLES);
  // Leaving HOLDOFF on the edge where the period count becomes PERIOD-1
  // puts the next IDLE decision exactly PERIOD clocks after the last one.
  localparam logic [PER_W-1:0]  PER_EXIT  = PER_W'(PERIOD_CYCLES - 2);
  localparam logic [PER_W-1:0]  PER_MAX   = PER_W'(PERIOD_CYCLES - 1);

  // The period must cover trigger, full echo window and the FSM hops
  if ((TRIG_CYCLES == 0) || (ECHO_TIMEOUT_CYCLES == 0) || (PERIOD_CYCLES == 0) ||
      (64'(PERIOD_CYCLES) < 64'(TRIG_CYCLES) + 64'(ECHO_TIMEOUT_CYCLES) + 64'd4))
  begin : g_param_check
    $error("ultrasonic_sensor_trigger: illegal TRIG/ECHO_TIMEOUT/PERIOD parameters");
  end

  hcsr04_state_t     state_reg;
  logic [TRIG_W-1:0] trig_cnt_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [PER_W-1:0]  per_cnt_reg;
  logic              echo_prev_reg;
  logic              armed_reg;
  logic              trigger_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              timeout_reg;
  logic              echo_sync;
  logic              echo_rise;
  logic              echo_fall;
  logic              tmo_hit;

  hcsr04_sync2 u_echo_sync (
    .Clk_i   (Clk_i),
    .Reset_i (Reset_i),
    .Async_i (Echo_i),
    .Sync_o  (echo_sync)
  );

  assign echo_rise = echo_sync & ~echo_prev_reg;
  assign echo_fall = ~echo_sync & echo_prev_reg;
  assign tmo_hit   = (tmo_cnt_reg == TMO_LAST);

  // Edge-detect history and a one-clock arm delay after reset release
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      echo_prev_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      echo_prev_reg <= echo_sync;
      armed_reg     <= 1'b1;
    end
  end

  // Measurement sequencer with its counters and registered outputs
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_reg    <= ST_IDLE;
      trig_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      per_cnt_reg  <= '0;
      trigger_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      if (per_cnt_reg != PER_MAX) begin
        per_cnt_reg <= per_cnt_reg + 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (armed_reg && (Enable_i || Start_i)) begin
            state_reg    <= ST_TRIG;
            trigger_reg  <= 1'b1;
            busy_reg     <= 1'b1;
            trig_cnt_reg <= '0;
            per_cnt_reg  <= '0;
          end
        end
        ST_TRIG: begin
          if (trig_cnt_reg == TRIG_LAST) begin
            state_reg   <= ST_WAIT_RISE;
            trigger_reg <= 1'b0;
            tmo_cnt_reg <= '0;
          end else begin
            trig_cnt_reg <= trig_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_RISE: begin
          if (tmo_cnt_reg != TMO_MAX) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
          if (tmo_hit) begin
            state_reg   <= ST_HOLDOFF;
            timeout_reg <= 1'b1;
          end else if (echo_rise) begin
            state_reg <= ST_ECHO_HIGH;
          end
        end
        ST_ECHO_HIGH: begin
          if (tmo_cnt_reg != TMO_MAX) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
          // A fall seen on the final window clock still counts as valid
          if (echo_fall) begin
            state_reg <= ST_HOLDOFF;
            done_reg  <= 1'b1;
          end else if (tmo_hit) begin
            state_reg   <= ST_HOLDOFF;
            timeout_reg <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (per_cnt_reg >= PER_EXIT) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          trigger_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign Trigger_o   = trigger_reg;
  assign Echo_sync_o = echo_sync;
  assign Busy_o      = busy_reg;
  assign Done_o      = done_reg;
  assign Timeout_o   = timeout_reg;

endmodule

// File: tb/tb_ultrasonic_sensor_trigger.sv
// Bench for ultrasonic_sensor_trigger: records inputs/outputs per clock edge,
// then derives the expected waveform from measurement timing arithmetic.
module tb_ultrasonic_sensor_trigger;

  localparam int T    = 5;
  localparam int E    = 60;
  localparam int P    = 100;
  localparam int MAXN = 1600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic start = 1'b0;
  logic echo = 1'b0;
  logic trig, echo_sync, busy, done, tmo;

  int checks = 0;
  int errors = 0;

  // Per-edge record: inputs seen at edge n, outputs just after edge n
  logic in_en [MAXN];
  logic in_start [MAXN];
  logic in_echo [MAXN];
  logic o_trig [MAXN];
  logic o_sync [MAXN];
  logic o_busy [MAXN];
  logic o_done [MAXN];
  logic o_tmo [MAXN];
  logic x_trig [MAXN];
  logic x_sync [MAXN];
  logic x_busy [MAXN];
  logic x_done [MAXN];
  logic x_tmo [MAXN];

  ultrasonic_sensor_trigger #(
    .TRIG_CYCLES         (T),
    .ECHO_TIMEOUT_CYCLES (E),
    .PERIOD_CYCLES       (P)
  ) dut (
    .Clk_i       (clk),
    .Reset_i     (rst_n),
    .Enable_i    (en),
    .Start_i     (start),
    .Echo_i      (echo),
    .Trigger_o   (trig),
    .Echo_sync_o (echo_sync),
    .Busy_o      (busy),
    .Done_o      (done),
    .Timeout_o   (tmo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Synchronized echo value just after edge m: the raw echo two samples back
  function automatic logic sv(input int m, input int n_edges);
    if (m < 1 || (m - 1) >= n_edges) return 1'b0;
    return in_echo[m - 1];
  endfunction

  // Drive one segment from reset; echo responses follow observed trigger falls
  task automatic run_segment(input int mode, input int n_edges);
    int   rise_at;
    int   fall_at;
    logic en_lvl;
    rst_n = 1'b0;
    en = 1'b0;
    start = 1'b0;
    echo = 1'b0;
    repeat (3) @(negedge clk);
    rise_at = -1;
    fall_at = -1;
    if (mode == 0) begin rise_at = 16; fall_at = 36; end
    if (mode == 2) begin rise_at = 20; fall_at = 64; end
    en_lvl = (mode == 1) ? 1'b1 : ((mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0);
    rst_n = 1'b1;
    for (int n = 0; n < n_edges; n++) begin
      if (mode == 3 && $urandom_range(0, 149) == 0) en_lvl = ~en_lvl;
      en = en_lvl;
      case (mode)
        0:       start = (n == 1 || n == 12 || n == 30 || n == 80 || n == 100 || n == 150);
        2:       start = (n == 1);
        3:       start = ($urandom_range(0, 24) == 0);
        default: start = 1'b0;
      endcase
      echo = (n >= rise_at && n < fall_at);
      in_en[n] = en;
      in_start[n] = start;
      in_echo[n] = echo;
      @(posedge clk);
      @(negedge clk);
      o_trig[n] = trig;
      o_sync[n] = echo_sync;
      o_busy[n] = busy;
      o_done[n] = done;
      o_tmo[n] = tmo;
      if ((mode == 1 || mode == 3) && n > 0 && o_trig[n-1] && !trig) begin
        if (mode == 1) begin
          rise_at = n + 9;
          fall_at = rise_at + 10;
        end else if ($urandom_range(0, 5) == 0) begin
          rise_at = -1;
          fall_at = -1;
        end else begin
          rise_at = n + 1 + int'($urandom_range(0, 75));
          fall_at = rise_at + int'($urandom_range(1, 70));
        end
      end
    end
    start = 1'b0;
    en = 1'b0;
    echo = 1'b0;
  endtask

  // Expected waveform from measurement timing, then edge-by-edge comparison
  task automatic model_and_compare(input int seg, input int n_edges);
    int n, k, r, f, win_hi;
    for (int i = 0; i < n_edges; i++) begin
      x_trig[i] = 1'b0;
      x_busy[i] = 1'b0;
      x_done[i] = 1'b0;
      x_tmo[i] = 1'b0;
      x_sync[i] = sv(i, n_edges);
    end
    n = 1;  // the first edge after reset release cannot start a measurement
    while (n < n_edges) begin
      if (in_en[n] || in_start[n]) begin
        k = n;
        win_hi = k + T + E;
        for (int j = k; j < k + T && j < n_edges; j++) x_trig[j] = 1'b1;
        for (int j = k; j <= k + P - 2 && j < n_edges; j++) x_busy[j] = 1'b1;
        r = -1;
        f = -1;
        for (int j = k + T + 1; j < win_hi && r < 0; j++)
          if (sv(j - 1, n_edges) && !sv(j - 2, n_edges)) r = j;
        if (r >= 0)
          for (int j = r + 1; j <= win_hi && f < 0; j++)
            if (!sv(j - 1, n_edges) && sv(j - 2, n_edges)) f = j;
        if (f >= 0) begin
          if (f < n_edges) x_done[f] = 1'b1;
          $display("seg %0d txn: trigger edge %0d -> done at edge %0d", seg, k, f);
        end else begin
          if (win_hi < n_edges) x_tmo[win_hi] = 1'b1;
          $display("seg %0d txn: trigger edge %0d -> timeout at edge %0d", seg, k, win_hi);
        end
        n = k + P;
      end else begin
        n++;
      end
    end
    for (int i = 0; i < n_edges; i++) begin
      check_val($sformatf("s%0d e%0d trigger", seg, i), 32'(o_trig[i]), 32'(x_trig[i]));
      check_val($sformatf("s%0d e%0d echo_sync", seg, i), 32'(o_sync[i]), 32'(x_sync[i]));
      check_val($sformatf("s%0d e%0d busy", seg, i), 32'(o_busy[i]), 32'(x_busy[i]));
      check_val($sformatf("s%0d e%0d done", seg, i), 32'(o_done[i]), 32'(x_done[i]));
      check_val($sformatf("s%0d e%0d timeout", seg, i), 32'(o_tmo[i]), 32'(x_tmo[i]));
    end
  endtask

  // Observed trigger rising edges under continuous enable are one period apart
  task automatic check_spacing(input int n_edges);
    int last, cnt;
    last = -1;
    cnt = 0;
    for (int i = 0; i < n_edges; i++) begin
      if (o_trig[i] && (i == 0 || !o_trig[i-1])) begin
        if (last >= 0) check_val($sformatf("rise spacing at edge %0d", i), 32'(i - last), 32'(P));
        last = i;
        cnt++;
      end
    end
    check_val("rising edge count >= 5", 32'(cnt >= 5), 32'd1);
  endtask

  // Reset asserted during the third trigger clock must clear everything at once
  task automatic reset_test();
    int trig_hi, busy_hi, done_hi, tmo_hi;
    rst_n = 1'b0;
    en = 1'b0;
    start = 1'b0;
    echo = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);            // edge 0: not yet armed
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);            // edge 1: trigger starts
    @(negedge clk);
    start = 1'b0;
    check_val("rst: trigger before reset", 32'(trig), 32'd1);
    check_val("rst: echo_sync before reset", 32'(echo_sync), 32'd1);
    @(posedge clk);
    @(posedge clk);            // inside trigger clock 3
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst: trigger async", 32'(trig), 32'd0);
    check_val("rst: busy async", 32'(busy), 32'd0);
    check_val("rst: done async", 32'(done), 32'd0);
    check_val("rst: timeout async", 32'(tmo), 32'd0);
    check_val("rst: echo_sync async", 32'(echo_sync), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    trig_hi = 0;
    busy_hi = 0;
    done_hi = 0;
    tmo_hi = 0;
    for (int i = 0; i < 200; i++) begin
      echo = 1'($urandom_range(0, 1));
      @(negedge clk);
      trig_hi += int'(trig);
      busy_hi += int'(busy);
      done_hi += int'(done);
      tmo_hi += int'(tmo);
    end
    echo = 1'b0;
    $display("reset txn: aborted trigger, 200 idle clocks observed");
    check_val("rst: trigger after release", 32'(trig_hi), 32'd0);
    check_val("rst: busy after release", 32'(busy_hi), 32'd0);
    check_val("rst: done after release", 32'(done_hi), 32'd0);
    check_val("rst: timeout after release", 32'(tmo_hi), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    run_segment(0, 300);
    model_and_compare(0, 300);
    run_segment(1, 520);
    model_and_compare(1, 520);
    check_spacing(520);
    run_segment(2, 150);
    model_and_compare(2, 150);
    for (int s = 3; s < 7; s++) begin
      run_segment(3, 1500);
      model_and_compare(s, 1500);
    end
    reset_test();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ultrasonic_sensor_trigger.md
ULTRASONIC_SENSOR_TRIGGER -- requirements
Module: ultrasonic_sensor_trigger

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 500, trigger pulse width in clocks (10 us at 50 MHz).
REQ-002 SHALL have parameter ECHO_TIMEOUT_CYCLES, default 1_900_000, max clocks from trigger fall to echo fall (38 ms).
REQ-003 SHALL have parameter PERIOD_CYCLES, default 3_000_000, min clocks between trigger rising edges (60 ms).
REQ-004 Clk_i  input  1  system clock; reset Reset_i, asynchronous, active-low; clock Clk_i.
REQ-005 Reset_i  input  1  asynchronous active-low reset.
REQ-006 Enable_i  input  1  level; continuous ranging while high.
REQ-007 Start_i  input  1  single-cycle request for one measurement.
REQ-008 Echo_i  input  1  raw asynchronous sensor echo pin.
REQ-009 Trigger_o  output  1  sensor trigger pin.
REQ-010 Echo_sync_o  output  1  echo after 2-flop synchronizer, feeds downstream echo-measurement stage.
REQ-011 Busy_o  output  1  high in every state except IDLE.
REQ-012 Done_o  output  1  one-cycle pulse on valid echo completion.
REQ-013 Timeout_o  output  1  one-cycle pulse when echo window expires.

Function
REQ-014 SHALL synchronize Echo_i through two flops; Echo_sync_o = second flop, latency 2 clocks; edges detected on Echo_sync_o only.
REQ-015 SHALL implement FSM states IDLE, TRIG, WAIT_RISE, ECHO_HIGH, HOLDOFF.
REQ-016 IDLE -> TRIG on (Enable_i high or Start_i high); Start_i outside IDLE ignored, not queued.
REQ-017 TRIG: Trigger_o high exactly TRIG_CYCLES clocks, registered, starting the cycle after the IDLE decision; echo edges ignored; then -> WAIT_RISE.
REQ-018 Timeout counter SHALL clear at TRIG exit and count every clock in WAIT_RISE and ECHO_HIGH.
REQ-019 WAIT_RISE -> ECHO_HIGH on Echo_sync_o rising edge.
REQ-020 ECHO_HIGH -> HOLDOFF on Echo_sync_o falling edge, pulsing Done_o for one clock.
REQ-021 WAIT_RISE or ECHO_HIGH -> HOLDOFF when timeout counter reaches ECHO_TIMEOUT_CYCLES, pulsing Timeout_o for one clock.
REQ-022 Echo fall and timeout in the same clock: Done_o SHALL pulse, Timeout_o SHALL NOT.
REQ-023 Period counter SHALL clear on entry to TRIG and count every clock; HOLDOFF -> IDLE when it reaches PERIOD_CYCLES-1, so consecutive trigger rising edges are exactly PERIOD_CYCLES apart under continuous Enable_i.
REQ-024 Enable_i deassert mid-cycle: current cycle completes normally, no new cycle starts.
REQ-025 Counter widths SHALL be clog2 of their terminal values; counters saturate, never wrap.
REQ-026 SHALL fail elaboration if PERIOD_CYCLES < TRIG_CYCLES + ECHO_TIMEOUT_CYCLES + 4 or any parameter is zero.

Reset
REQ-027 Reset_i low SHALL force immediately: state IDLE, Trigger_o 0, Busy_o 0, Done_o 0, Timeout_o 0, Echo_sync_o 0, all counters 0.
REQ-028 Reset mid-trigger SHALL drop Trigger_o asynchronously; no Done_o/Timeout_o pulse from the aborted cycle.
REQ-029 After reset release, first trigger SHALL occur no earlier than the second clock edge.

Structure
REQ-030 State encodings and default cycle constants SHALL live in the shared hcsr04 parameters package used by the echo stage.
REQ-031 Synchronizer SHALL be one sub-module, hcsr04_sync2 (2 flops, async active-low reset to 0).
REQ-032 Sole sub-module; no vendor IP.

Verification (bench params TRIG_CYCLES=5, ECHO_TIMEOUT_CYCLES=60, PERIOD_CYCLES=100)
REQ-033 Start_i 1 clock, Enable_i 0 -> Trigger_o high exactly 5 clocks, Busy_o high, echo high 20 clocks after trigger fall -> Done_o single pulse 2 clocks after Echo_i fall, return to IDLE at cycle 100.
REQ-034 Enable_i held 1, echo 10 clocks each cycle -> trigger rising edges exactly 100 clocks apart across 5 cycles.
REQ-035 Echo_i never rises -> Timeout_o single pulse 60 clocks after Trigger_o fall, no Done_o.
REQ-036 Echo_sync_o falls on the clock the counter reaches 60 -> Done_o 1, Timeout_o 0.
REQ-037 Reset_i low on trigger clock 3 -> Trigger_o 0 same time step, all outputs 0, no pulses after release.
REQ-038 Start_i pulsed in WAIT_RISE and HOLDOFF -> ignored; exactly one trigger per requested cycle.
